// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and constants for the ALU scheduler.
// FSM state encoding, ALU opcode values, and the round-robin pointer step.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sched_state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  // Index following a granted requester, wrapping at n.
  function automatic int ptr_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational requester pick with one-hot and binary grant.
// Default: search upward from ptr with wrap. With ALU_SCHED_FIXED_PRIO_EN
// defined the pointer is ignored and the lowest requesting index wins.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  logic [IW-1:0] idx;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Walk candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      idx = IW'(k);
`else
      idx = IW'((int'(ptr) + k) % N_REQ);
`endif
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one external combinational ALU among N_REQ
// requesters. IDLE grants one request and latches its operands, ISSUE
// captures the ALU result, RESP holds a tagged response until accepted.
// Build option: ALU_SCHED_FIXED_PRIO_EN selects fixed priority in rr_arbiter.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int W     = 4,
  parameter  int OPW   = 3,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  input  logic [N_REQ*OPW-1:0] req_op,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic [OPW-1:0]       alu_op,
  input  logic [W-1:0]         alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic [15:0]          ops_done
);

  logic [N_REQ-1:0][W-1:0]   a_arr, b_arr;
  logic [N_REQ-1:0][OPW-1:0] op_arr;

  assign a_arr  = req_a;
  assign b_arr  = req_b;
  assign op_arr = req_op;

  sched_state_t   state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [IW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [15:0]    ops_done_q, ops_done_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Grant is only offered while idle and out of reset, so ready implies accept.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

  // Next-state and datapath updates; everything holds unless the FSM advances.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          alu_a_d  = a_arr[gnt_idx];
          alu_b_d  = b_arr[gnt_idx];
          alu_op_d = op_arr[gnt_idx];
          rsp_id_d = gnt_idx;
          rr_ptr_d = IW'(ptr_inc(int'(gnt_idx), N_REQ));
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rsp_result_d = alu_result;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight operation without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_valid  = rsp_valid_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: scoreboard bench for alu_scheduler with an ALU model.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int N   = 2;
  localparam int W   = 4;
  localparam int OPW = 3;
  localparam int IW  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [N*OPW-1:0] req_op;
  logic [W-1:0]     alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;
  logic             rsp_valid, rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [W-1:0]     rsp_result;
  logic [15:0]      ops_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    logic [3:0] res;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_ops = 16'h0;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LT:   return {3'b000, (a < b)};
      default: return {3'b000, (a == b)};
    endcase
  endfunction

  always #5 clk = ~clk;

  alu_scheduler #(.N_REQ(N), .W(W), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .ops_done   (ops_done)
  );

  // External ALU beside the scheduler.
  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_ops = 16'h0;
    end else begin
      total++;
      if (ops_done !== exp_ops) begin
        bad++;
        $display("FAIL ops_done got=%0h want=%0h", ops_done, exp_ops);
      end
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp got id=%0d res=%0h want=none", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== IW'(e.id) || rsp_result !== e.res) begin
            bad++;
            $display("FAIL rsp got id=%0d res=%0h want id=%0d res=%0h",
                     rsp_id, rsp_result, e.id, e.res);
          end
        end
        exp_ops = exp_ops + 16'd1;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back('{i, alu_f(req_a[i*W +: W], req_b[i*W +: W], req_op[i*OPW +: OPW])});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
    req_op[i*OPW +: OPW] = op;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 20 && (sb.size() != 0 || rsp_valid); c++) step();
    total++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d rsp_valid=%0b want 0/0", sb.size(), rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    set_req(0, 4'h3, 4'h4, OP_OR);
    set_req(1, 4'h6, 4'h1, OP_SUB);
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      total++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || ops_done !== 16'h0) begin
        bad++;
        $display("FAIL reset_ctl got rdy=%b vld=%b ops=%0h want 00/0/0", req_ready, rsp_valid, ops_done);
      end
      total++;
      if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'h0) begin
        bad++;
        $display("FAIL reset_alu got a=%0h b=%0h op=%0h want 0/0/0", alu_a, alu_b, alu_op);
      end
    end
    step();
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    step();
    set_req(0, 4'h3, 4'h5, OP_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL single_grant got=%b want=01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    total++;
    if (alu_a !== 4'h3 || alu_b !== 4'h5 || alu_op !== OP_ADD || req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_issue got a=%0h b=%0h op=%0h rdy=%b vld=%b want 3/5/0/00/0",
               alu_a, alu_b, alu_op, req_ready, rsp_valid);
    end
    step();
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'h8 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL single_resp got vld=%b res=%0h id=%0d want 1/8/0", rsp_valid, rsp_result, rsp_id);
    end
    step();
    #1;
    total++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'd1) begin
      bad++;
      $display("FAIL single_done got vld=%b ops=%0d want 0/1", rsp_valid, ops_done);
    end
  endtask

  task automatic test_backpressure();
    step();
    set_req(1, 4'h9, 4'h2, OP_SUB);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL bp_grant got=%b want=10", req_ready);
    end
    step();
    set_req(0, 4'h1, 4'h1, OP_EQ);
    req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'h7 || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got vld=%b res=%0h id=%0d rdy=%b want 1/7/1/00",
                 c, rsp_valid, rsp_result, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    step();
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0/01", rsp_valid, req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_contention();
    int got[$];
    int want;
    set_req(0, 4'hC, 4'hA, OP_AND);
    set_req(1, 4'h2, 4'h9, OP_LT);
    rsp_ready = 1'b1;
    step();
    req_valid = 2'b11;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      #1;
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) got.push_back(i);
      if (got.size() < 4) step();
    end
    step();
    req_valid = 2'b00;
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL contention_count got=%0d want=4", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      want = 0;
`else
      want = k % 2;
`endif
      total++;
      if (got[k] != want) begin
        bad++;
        $display("FAIL contention_order k=%0d got=%0d want=%0d", k, got[k], want);
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    step();
    set_req(0, 4'h5, 4'h6, OP_XOR);
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rmid_grant got=%b want=01", req_ready);
    end
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_issue got rdy=%b vld=%b want 00/0", req_ready, rsp_valid);
    end
    step();
    rst = 1'b0;
    set_req(1, 4'h4, 4'h4, OP_EQ);
    req_valid = 2'b11;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'h0 || req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rmid_after got vld=%b ops=%0d rdy=%b want 0/0/01", rsp_valid, ops_done, req_ready);
    end
    step();
    req_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_wrap();
    step();
    force dut.ops_done_q = 16'hFFFF;
    exp_ops = 16'hFFFF;
    #1;
    release dut.ops_done_q;
    #1;
    total++;
    if (ops_done !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload got=%0h want=ffff", ops_done);
    end
    set_req(1, 4'hF, 4'h1, OP_ADD);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_drain();
    #1;
    total++;
    if (ops_done !== 16'h0000) begin
      bad++;
      $display("FAIL wrap got=%0h want=0", ops_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_reset_mid();
    test_wrap();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
